// File: rtl/player_jump_if.sv
// Signal bundle between the game-state controller and the player jump sequencer.
// The master drives frame strobe, enables and keycode; the slave returns motion state.
interface player_jump_if;
    logic              frame_tick;
    logic              run_en;
    logic              internal_reset;
    logic [7:0]        keycode;
    logic [9:0]        player_y;
    logic signed [7:0] player_vy;
    logic              airborne;
    logic              landed;

    modport master (
        output frame_tick, run_en, internal_reset, keycode,
        input  player_y, player_vy, airborne, landed
    );

    modport slave (
        input  frame_tick, run_en, internal_reset, keycode,
        output player_y, player_vy, airborne, landed
    );
endinterface

// File: rtl/player_jump_ctrl.sv
// Player cube vertical motion: latches jump key presses and steps position/velocity
// once per video frame through GROUND -> RISE -> FALL -> GROUND.
module player_jump_ctrl #(
    parameter logic [9:0] GROUND_Y = 10'd400,
    parameter logic [7:0] JUMP_V   = 8'd12,
    parameter logic [7:0] GRAV     = 8'd1,
    parameter logic [7:0] MAX_FALL = 8'd15,
    parameter logic [7:0] JUMP_KEY = 8'h1A
) (
    input logic         Clk,
    input logic         Reset,
    player_jump_if.slave bus
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    state_t            state_q, state_d;
    logic [9:0]        y_q, y_d;
    logic signed [7:0] vy_q, vy_d;
    logic              landed_q, landed_d;
    logic              pend_q, pend_d;

    logic signed [10:0] y_sum;
    logic signed [8:0]  vy_sum;
    logic               key_hit;

    // Widened sums so a rise past the ceiling or a drop past the floor cannot wrap.
    assign y_sum   = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
    assign vy_sum  = $signed({vy_q[7], vy_q}) + $signed({1'b0, GRAV});
    assign key_hit = bus.run_en && (bus.keycode == JUMP_KEY);

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vy_d     = vy_q;
        landed_d = 1'b0;
        pend_d   = pend_q;

        if (bus.internal_reset) begin
            state_d = GROUND;
            y_d     = GROUND_Y;
            vy_d    = '0;
            pend_d  = 1'b0;
        end else if (bus.run_en) begin
            if (bus.frame_tick) begin
                pend_d = 1'b0;
                case (state_q)
                    GROUND: begin
                        // Launch only sets velocity; position starts moving next frame.
                        if (pend_q || key_hit) begin
                            vy_d    = $signed(8'd0 - JUMP_V);
                            state_d = RISE;
                        end
                    end
                    RISE: begin
                        if (y_sum[10]) begin
                            y_d     = '0;
                            vy_d    = '0;
                            state_d = FALL;
                        end else begin
                            y_d  = y_sum[9:0];
                            vy_d = vy_sum[7:0];
                            if (!vy_sum[8]) begin
                                state_d = FALL;
                            end
                        end
                    end
                    FALL: begin
                        if (y_sum >= $signed({1'b0, GROUND_Y})) begin
                            y_d      = GROUND_Y;
                            vy_d     = '0;
                            state_d  = GROUND;
                            landed_d = 1'b1;
                        end else begin
                            y_d  = y_sum[9:0];
                            vy_d = (vy_sum > $signed({1'b0, MAX_FALL})) ? MAX_FALL : vy_sum[7:0];
                        end
                    end
                    default: state_d = GROUND;
                endcase
            end else if (key_hit) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= GROUND;
            y_q      <= GROUND_Y;
            vy_q     <= '0;
            landed_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            landed_q <= landed_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.player_y  = y_q;
    assign bus.player_vy = vy_q;
    assign bus.airborne  = (state_q != GROUND);
    assign bus.landed    = landed_q;

endmodule

// File: tb/tb_player_jump_ctrl.sv
// Bench for player_jump_ctrl: a default instance and a low-ceiling / low-terminal-speed
// instance share stimulus; a per-cycle reference model feeds a scoreboard queue.
module tb_player_jump_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       run_en;
    logic       internal_reset;
    logic [7:0] keycode;

    always #5 Clk = ~Clk;

    player_jump_if ifa ();
    player_jump_if ifb ();

    assign ifa.frame_tick     = frame_tick;
    assign ifa.run_en         = run_en;
    assign ifa.internal_reset = internal_reset;
    assign ifa.keycode        = keycode;
    assign ifb.frame_tick     = frame_tick;
    assign ifb.run_en         = run_en;
    assign ifb.internal_reset = internal_reset;
    assign ifb.keycode        = keycode;

    player_jump_ctrl dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifa.slave)
    );

    player_jump_ctrl #(
        .GROUND_Y (10'd40),
        .JUMP_V   (8'd60),
        .GRAV     (8'd1),
        .MAX_FALL (8'd4),
        .JUMP_KEY (8'h1A)
    ) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifb.slave)
    );

    typedef struct {
        int y;
        int vy;
        int st;      // 0 ground, 1 rise, 2 fall
        int pend;
        int landed;
    } mstate_t;

    typedef struct {
        int ya, vya, aira, lda;
        int yb, vyb, airb, ldb;
    } exp_t;

    mstate_t ma, mb;
    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    int      tick_no = 0;
    int      ld_cnt_a = 0;
    int      ld_cnt_b = 0;
    int      max_vy_b = -1000;
    int      max_y_b  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mstate_t mstep(input mstate_t s, input int gy, input int jv, input int mf);
        mstate_t n = s;
        int ny, nv;
        bit req;
        n.landed = 0;
        if (Reset || internal_reset) begin
            n.y = gy; n.vy = 0; n.st = 0; n.pend = 0;
        end else if (run_en) begin
            if (frame_tick) begin
                req = (s.pend != 0) || (keycode == 8'h1A);
                n.pend = 0;
                ny = s.y + s.vy;
                nv = s.vy + 1;
                if (s.st == 0) begin
                    if (req) begin n.vy = -jv; n.st = 1; end
                end else if (s.st == 1) begin
                    if (ny < 0) begin
                        n.y = 0; n.vy = 0; n.st = 2;
                    end else begin
                        n.y = ny; n.vy = nv;
                        if (nv >= 0) n.st = 2;
                    end
                end else begin
                    if (ny >= gy) begin
                        n.y = gy; n.vy = 0; n.st = 0; n.landed = 1;
                    end else begin
                        n.y = ny; n.vy = (nv > mf) ? mf : nv;
                    end
                end
            end else if (keycode == 8'h1A) begin
                n.pend = 1;
            end
        end
        return n;
    endfunction

    task automatic step();
        exp_t e;
        bit   was_tick;
        was_tick = frame_tick && run_en && !Reset && !internal_reset;
        ma = mstep(ma, 400, 12, 15);
        mb = mstep(mb, 40, 60, 4);
        e.ya = ma.y; e.vya = ma.vy; e.aira = (ma.st != 0); e.lda = ma.landed;
        e.yb = mb.y; e.vyb = mb.vy; e.airb = (mb.st != 0); e.ldb = mb.landed;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("a_y",      int'(ifa.player_y),  e.ya);
        chk("a_vy",     int'(ifa.player_vy), e.vya);
        chk("a_air",    int'(ifa.airborne),  e.aira);
        chk("a_landed", int'(ifa.landed),    e.lda);
        chk("b_y",      int'(ifb.player_y),  e.yb);
        chk("b_vy",     int'(ifb.player_vy), e.vyb);
        chk("b_air",    int'(ifb.airborne),  e.airb);
        chk("b_landed", int'(ifb.landed),    e.ldb);
        ld_cnt_a += int'(ifa.landed);
        ld_cnt_b += int'(ifb.landed);
        if (int'(ifb.player_vy) > max_vy_b) max_vy_b = int'(ifb.player_vy);
        if (int'(ifb.player_y) > max_y_b)   max_y_b  = int'(ifb.player_y);
        if (was_tick) begin
            tick_no++;
            $display("tick %0d  a: y=%0d vy=%0d air=%0b land=%0b  b: y=%0d vy=%0d air=%0b land=%0b",
                     tick_no, ifa.player_y, ifa.player_vy, ifa.airborne, ifa.landed,
                     ifb.player_y, ifb.player_vy, ifb.airborne, ifb.landed);
        end
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic press();
        keycode = 8'h1A;
        step();
        keycode = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ld0, ldb0, n, ys, vys, prev_air;
        int launches[$];

        Reset = 1'b1; frame_tick = 1'b0; run_en = 1'b1; internal_reset = 1'b0; keycode = 8'h00;
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
        repeat (2) step();
        chk("rst_y", int'(ifa.player_y), 400);
        chk("rst_vy", int'(ifa.player_vy), 0);
        chk("rst_air", int'(ifa.airborne), 0);
        Reset = 1'b0;

        // Idle frames with no key.
        frame(5);
        chk("idle_y", int'(ifa.player_y), 400);
        chk("idle_landed_cnt", ld_cnt_a, 0);

        // Short press between ticks, then full trajectory.
        ld0 = ld_cnt_a; ldb0 = ld_cnt_b;
        press();
        frame(1);
        chk("launch_y", int'(ifa.player_y), 400);
        chk("launch_vy", int'(ifa.player_vy), -12);
        frame(1);
        chk("b_ceil_y", int'(ifb.player_y), 0);
        chk("b_ceil_vy", int'(ifb.player_vy), 0);
        chk("b_ceil_air", int'(ifb.airborne), 1);
        frame(11);
        chk("apex_y", int'(ifa.player_y), 322);
        chk("apex_vy", int'(ifa.player_vy), 0);
        chk("apex_air", int'(ifa.airborne), 1);
        frame(12);
        chk("pre_land_air", int'(ifa.airborne), 1);
        frame(1);
        chk("land_y", int'(ifa.player_y), 400);
        chk("land_air", int'(ifa.airborne), 0);
        chk("land_pulses", ld_cnt_a - ld0, 1);
        chk("b_land_pulses", ld_cnt_b - ldb0, 1);
        chk("b_max_vy_le4", int'(max_vy_b <= 4), 1);
        chk("b_max_y_le40", int'(max_y_b <= 40), 1);

        // Held key: auto-repeat, launch-to-launch period.
        keycode = 8'h1A;
        prev_air = 0;
        for (int f = 0; f < 60; f++) begin
            frame(1);
            if (!prev_air && ifa.airborne) launches.push_back(tick_no);
            prev_air = int'(ifa.airborne);
        end
        keycode = 8'h00;
        chk("hold_launches", launches.size(), 3);
        if (launches.size() >= 3) begin
            chk("hold_period1", launches[1] - launches[0], 26);
            chk("hold_period2", launches[2] - launches[1], 26);
        end
        n = 0;
        while (n < 40 && (ifa.airborne || ifb.airborne)) begin
            frame(1);
            n++;
        end
        chk("hold_settle", int'(ifa.airborne), 0);

        // Freeze mid-air with run_en low, then resume.
        press();
        frame(1);
        frame(6);
        ys = int'(ifa.player_y); vys = int'(ifa.player_vy);
        chk("pre_freeze_y", ys, 343);
        chk("pre_freeze_vy", vys, -6);
        run_en = 1'b0;
        keycode = 8'h1A;
        frame(10);
        keycode = 8'h00;
        chk("freeze_y", int'(ifa.player_y), 343);
        chk("freeze_vy", int'(ifa.player_vy), -6);
        run_en = 1'b1;
        ld0 = ld_cnt_a;
        n = 0;
        while (n < 40 && ld_cnt_a == ld0) begin
            frame(1);
            n++;
        end
        chk("resume_ticks_to_land", n, 19);
        frame(2);

        // internal_reset mid-air, with a key press in the same cycle.
        press();
        frame(5);
        chk("ir_pre_air", int'(ifa.airborne), 1);
        ld0 = ld_cnt_a;
        internal_reset = 1'b1;
        keycode = 8'h1A;
        step();
        internal_reset = 1'b0;
        keycode = 8'h00;
        chk("ir_y", int'(ifa.player_y), 400);
        chk("ir_vy", int'(ifa.player_vy), 0);
        chk("ir_air", int'(ifa.airborne), 0);
        chk("ir_landed", int'(ifa.landed), 0);
        frame(3);
        chk("ir_no_launch", int'(ifa.airborne), 0);
        chk("ir_no_land_pulse", ld_cnt_a - ld0, 0);

        // frame_tick and key while Reset is high are ignored.
        Reset = 1'b1;
        keycode = 8'h1A;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        Reset = 1'b0;
        keycode = 8'h00;
        frame(2);
        chk("rst_tick_air", int'(ifa.airborne), 0);
        chk("rst_tick_y", int'(ifa.player_y), 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_jump_ctrl.md
# player_jump_ctrl

Sequences the player cube's vertical motion during gameplay: it turns jump key presses into a per-frame velocity and position profile, with rise, apex, fall and landing. It sits between the top-level game-state controller (which supplies the run enable and the death-reset pulse) and the ball/sprite datapath and color mapper. Those blocks consume its Y position and velocity once per video frame.

## Interface
Parameters:
- GROUND_Y, 10'd400: Y of the player's top edge when resting on the floor (pixels).
- JUMP_V, 8'd12: launch speed in pixels/frame; applied as the negative velocity -JUMP_V.
- GRAV, 8'd1: velocity increment per frame while airborne.
- MAX_FALL, 8'd15: positive velocity cap (terminal fall speed).
- JUMP_KEY, 8'h1A: keycode that requests a jump.

Ports:
- Clk, input, 1: system clock. Everything is on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse per video frame (vsync-derived). This is the motion update strobe.
- run_en, input, 1: high while in the gameplay screen. Low freezes all motion.
- internal_reset, input, 1: death/restart pulse from the game-state controller.
- keycode, input, 8: current keyboard keycode.
- player_y, output, 10: current top-edge Y of the player.
- player_vy, output, 8 signed: current vertical velocity, in pixels/frame (negative = up).
- airborne, output, 1: high in RISE or FALL.
- landed, output, 1: one-cycle pulse on the tick that the player touches down.

## Operation
- States:
  - GROUND: at rest.
  - RISE: vy < 0.
  - FALL: vy >= 0, airborne.
- Jump request latch (jump_pend):
  - Set on any cycle where run_en=1 and keycode==JUMP_KEY.
  - Cleared on every frame_tick, and by Reset or internal_reset.
  - A press shorter than one frame is therefore never lost.
  - A held key re-requests every frame, giving auto-repeat jumps.
- On frame_tick with run_en=1:
  - GROUND, jump_pend=1:
    - vy <= -JUMP_V, go to RISE.
    - player_y is unchanged this tick; motion starts on the next tick.
  - GROUND, jump_pend=0: no change.
  - RISE:
    - y <= y + vy.
    - vy <= vy + GRAV.
    - If the new vy >= 0, go to FALL.
    - If y + vy < 0: clamp y to 0, set vy to 0, go to FALL.
  - FALL:
    - If y + vy >= GROUND_Y: y <= GROUND_Y, vy <= 0, go to GROUND, assert landed.
    - Otherwise: y <= y + vy, vy <= min(vy + GRAV, MAX_FALL).
  - A jump request is ignored in RISE/FALL, with no buffering past the current tick.
- Arithmetic:
  - Compute the sum as an 11-bit signed value: zero-extended y plus sign-extended vy. This avoids wrap-around.
  - The velocity sum is computed 9-bit signed before the MAX_FALL compare.
- run_en=0:
  - State, player_y and player_vy hold.
  - frame_tick is ignored.
  - Keycodes are not latched.
- Priority per cycle: Reset > internal_reset > run_en=0 > frame_tick.

## Timing
- Reset or internal_reset (either one), registered on the next edge:
  - player_y=GROUND_Y, player_vy=0, airborne=0, landed=0.
  - State GROUND, jump_pend=0.
- Outputs are registered. They change only on the cycle after a frame_tick, a reset or an internal_reset.
- landed is high for exactly one Clk cycle, coincident with the first cycle where player_y=GROUND_Y and state is GROUND.
- Touchdown and jump on the same tick: landing completes on that tick. With the key still held, the new launch occurs on the following frame_tick, never on the landing tick.
- internal_reset mid-air: the player snaps to the ground on the next cycle, and landed is not asserted.
- frame_tick while Reset is high is ignored.
- With default parameters:
  - The launch tick is followed by 12 RISE ticks; the apex is y=322 with vy=0.
  - Then 13 FALL ticks; landing occurs on tick 25 after launch.

## Test plan
- Reset, then pulse 5 frame_ticks with no key -> player_y=400, player_vy=0, airborne=0, landed never asserted.
- Pulse keycode=8'h1A for one non-tick cycle, then frame_ticks -> launch tick gives vy=-12.
  - After 12 more ticks: y=322, vy=0, state FALL.
  - After 13 more: y=400, landed pulses once, airborne=0.
- Hold keycode=8'h1A continuously -> relaunch on the tick after each landing. Period is 26 frame_ticks from launch to launch.
- Mid-air (tick 6 after launch), drop run_en for 10 ticks -> y and vy frozen.
  - On re-enable, the trajectory resumes and lands at total tick 25 of enabled time.
- Mid-air, pulse internal_reset -> next cycle y=400, vy=0, airborne=0, landed=0.
  - A key press during internal_reset does not launch.
- Parameters JUMP_V=60, GRAV=1, GROUND_Y=40 -> the ceiling clamp hits y=0, vy=0, state FALL.
  - Lands back at 40 with landed pulse; no wrap to large Y values.
  - With MAX_FALL=4, vy never exceeds 4.
